// File: rtl/ysyx_210238_mem_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch and the LSU.
// LSU has priority; a saturating streak counter forces an IF grant after LS_STREAK_MAX LSU wins.
module ysyx_210238_mem_arbiter #(
  parameter int ADDR_W        = 64,
  parameter int DATA_W        = 64,
  parameter int LS_STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_if_valid,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic [2:0]        i_if_size,
  output logic              o_if_ready,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_ls_valid,
  input  logic              i_ls_wen,
  input  logic [ADDR_W-1:0] i_ls_addr,
  input  logic [DATA_W-1:0] i_ls_wdata,
  input  logic [2:0]        i_ls_size,
  output logic              o_ls_ready,
  output logic [DATA_W-1:0] o_ls_rdata,
  output logic              o_mem_valid,
  output logic              o_mem_wen,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [2:0]        o_mem_size,
  input  logic              i_mem_ready,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  localparam int SW = $clog2(LS_STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(LS_STREAK_MAX);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GNT_IF = 2'd1;
  localparam logic [1:0] ST_GNT_LS = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        size_q, size_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              grant_if, grant_ls;

  always_comb begin
    state_d  = state_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    streak_d = streak_q;
    grant_if = 1'b0;
    grant_ls = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // IF only beats a pending LSU request once the streak has saturated
        grant_if = i_if_valid && (!i_ls_valid || (streak_q == STREAK_MAX));
        grant_ls = i_ls_valid && !grant_if;
        if (grant_if) begin
          state_d  = ST_GNT_IF;
          wen_d    = 1'b0;
          addr_d   = i_if_addr;
          wdata_d  = '0;
          size_d   = i_if_size;
          streak_d = '0;
        end else if (grant_ls) begin
          state_d  = ST_GNT_LS;
          wen_d    = i_ls_wen;
          addr_d   = i_ls_addr;
          wdata_d  = i_ls_wdata;
          size_d   = i_ls_size;
          if (!i_if_valid) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + SW'(1);
          end
        end
      end
      ST_GNT_IF, ST_GNT_LS: begin
        if (i_mem_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    o_mem_valid = (state_q != ST_IDLE);
    o_busy      = (state_q != ST_IDLE);
    o_mem_wen   = wen_q;
    o_mem_addr  = addr_q;
    o_mem_wdata = wdata_q;
    o_mem_size  = size_q;
    o_if_ready  = (state_q == ST_GNT_IF) && i_mem_ready;
    o_ls_ready  = (state_q == ST_GNT_LS) && i_mem_ready;
    o_if_rdata  = o_if_ready ? i_mem_rdata : '0;
    o_ls_rdata  = o_ls_ready ? i_mem_rdata : '0;
  end

endmodule

// File: tb/tb_ysyx_210238_mem_arbiter.sv
// Scoreboard bench for ysyx_210238_mem_arbiter: directed requests, a latency-programmable
// memory responder, and a monitor that checks every downstream completion.
module tb_ysyx_210238_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_if_valid;
  logic [63:0] i_if_addr;
  logic [2:0]  i_if_size;
  logic        o_if_ready;
  logic [63:0] o_if_rdata;
  logic        i_ls_valid;
  logic        i_ls_wen;
  logic [63:0] i_ls_addr;
  logic [63:0] i_ls_wdata;
  logic [2:0]  i_ls_size;
  logic        o_ls_ready;
  logic [63:0] o_ls_rdata;
  logic        o_mem_valid;
  logic        o_mem_wen;
  logic [63:0] o_mem_addr;
  logic [63:0] o_mem_wdata;
  logic [2:0]  o_mem_size;
  logic        i_mem_ready;
  logic [63:0] i_mem_rdata;
  logic        o_busy;

  ysyx_210238_mem_arbiter #(
    .ADDR_W(64),
    .DATA_W(64),
    .LS_STREAK_MAX(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_if_valid(i_if_valid), .i_if_addr(i_if_addr), .i_if_size(i_if_size),
    .o_if_ready(o_if_ready), .o_if_rdata(o_if_rdata),
    .i_ls_valid(i_ls_valid), .i_ls_wen(i_ls_wen), .i_ls_addr(i_ls_addr),
    .i_ls_wdata(i_ls_wdata), .i_ls_size(i_ls_size),
    .o_ls_ready(o_ls_ready), .o_ls_rdata(o_ls_rdata),
    .o_mem_valid(o_mem_valid), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_size(o_mem_size),
    .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata), .o_busy(o_busy)
  );

  typedef struct {
    logic        is_ls;
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  size;
    logic [63:0] rdata;
  } txn_t;

  txn_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   vcount = 0;
  int   mem_lat = 0;
  logic stray_req = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no ready within cycle budget (got none, expected a pulse)", name);
  endtask

  // Memory content model: fixed instruction word at the reset vector, inverted address elsewhere
  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    return (a == 64'h0000_0000_8000_0000) ? 64'h0000_0000_0000_0013 : ~a;
  endfunction

  task automatic push(input logic l, input logic w, input logic [63:0] a,
                      input logic [63:0] d, input logic [2:0] s);
    txn_t t;
    t.is_ls = l; t.wen = w; t.addr = a; t.wdata = d; t.size = s; t.rdata = mem_rd(a);
    exp_q.push_back(t);
  endtask

  // Responder: answers mem_lat cycles after the request first appears
  initial begin
    int   cnt;
    logic rdy;
    cnt = 0;
    i_mem_ready = 1'b0;
    i_mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      rdy = 1'b0;
      if (o_mem_valid) begin
        if (cnt >= mem_lat) begin
          rdy = 1'b1;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
      i_mem_ready = rdy || stray_req;
      i_mem_rdata = rdy ? mem_rd(o_mem_addr) : (stray_req ? 64'hBAD0_BAD0_BAD0_BAD0 : '0);
    end
  end

  // Monitor: pops one expected transaction per downstream completion
  initial begin
    txn_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (o_mem_valid) vcount++;
        if (i_mem_ready && !o_mem_valid) begin
          check("stray_if_ready", 64'(o_if_ready), 64'd0);
          check("stray_ls_ready", 64'(o_ls_ready), 64'd0);
          check("stray_rdata", o_if_rdata | o_ls_rdata, 64'd0);
        end else if (i_mem_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_txn: got addr %h, expected no transaction", o_mem_addr);
          end else begin
            e = exp_q.pop_front();
            check("owner_ls_ready", 64'(o_ls_ready), 64'(e.is_ls));
            check("owner_if_ready", 64'(o_if_ready), 64'(!e.is_ls));
            check("mem_addr", o_mem_addr, e.addr);
            check("mem_wen", 64'(o_mem_wen), 64'(e.wen));
            check("mem_wdata", o_mem_wdata, e.wdata);
            check("mem_size", 64'(o_mem_size), 64'(e.size));
            check("owner_rdata", e.is_ls ? o_ls_rdata : o_if_rdata, e.rdata);
            check("other_rdata", e.is_ls ? o_if_rdata : o_ls_rdata, 64'd0);
          end
        end else if (o_mem_valid) begin
          check("rdata_zero_wait", o_if_rdata | o_ls_rdata, 64'd0);
          check("ready_zero_wait", 64'(o_if_ready | o_ls_ready), 64'd0);
        end
      end
    end
  end

  task automatic drive_if(input logic [63:0] a, input logic [2:0] s, output int lat);
    @(posedge clk);
    #1;
    i_if_valid = 1'b1;
    i_if_addr  = a;
    i_if_size  = s;
    lat = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (o_if_ready) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) timeout("if_ready");
    @(posedge clk);
    #1;
    i_if_valid = 1'b0;
  endtask

  task automatic ls_seq(input int n, input logic w, input logic [63:0] base,
                        input logic [63:0] wd, input logic [2:0] s, output int lat);
    @(posedge clk);
    #1;
    lat = -1;
    for (int k = 0; k < n; k++) begin
      i_ls_valid = 1'b1;
      i_ls_wen   = w;
      i_ls_addr  = base + 64'(8 * k);
      i_ls_wdata = wd + 64'(k);
      i_ls_size  = s;
      lat = -1;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (o_ls_ready) begin
          lat = c;
          break;
        end
      end
      if (lat < 0) timeout("ls_ready");
      @(posedge clk);
      #1;
    end
    i_ls_valid = 1'b0;
  endtask

  initial begin
    int lat_a, lat_b;
    rst_n      = 1'b0;
    i_if_valid = 1'b0;
    i_if_addr  = '0;
    i_if_size  = '0;
    i_ls_valid = 1'b0;
    i_ls_wen   = 1'b1;
    i_ls_addr  = 64'hFFFF_FFFF_FFFF_FFF8;
    i_ls_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    i_ls_size  = 3'd3;

    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_valid", 64'(o_mem_valid), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_ready", 64'(o_if_ready | o_ls_ready), 64'd0);
    check("rst_mem_addr", o_mem_addr, 64'd0);
    check("rst_mem_wdata", o_mem_wdata, 64'd0);
    check("rst_mem_wen_size", 64'({o_mem_wen, o_mem_size}), 64'd0);
    rst_n = 1'b1;

    // IF fetch, ready on the third cycle of the grant; LSU lines carry junk meanwhile
    mem_lat = 2;
    push(1'b0, 1'b0, 64'h8000_0000, 64'd0, 3'd2);
    vcount = 0;
    drive_if(64'h8000_0000, 3'd2, lat_a);
    check("if_only_latency", 64'(lat_a), 64'd3);
    check("if_only_valid_cycles", 64'(vcount), 64'd3);

    // LSU store, immediate ready
    mem_lat = 0;
    push(1'b1, 1'b1, 64'h8000_1000, 64'hDEAD_BEEF, 3'd2);
    ls_seq(1, 1'b1, 64'h8000_1000, 64'hDEAD_BEEF, 3'd2, lat_a);
    check("ls_store_latency", 64'(lat_a), 64'd1);

    // Simultaneous: LSU first, IF on the following IDLE cycle
    push(1'b1, 1'b0, 64'h8000_3000, 64'd0, 3'd3);
    push(1'b0, 1'b0, 64'h8000_0000, 64'd0, 3'd2);
    fork
      ls_seq(1, 1'b0, 64'h8000_3000, 64'd0, 3'd3, lat_a);
      drive_if(64'h8000_0000, 3'd2, lat_b);
    join
    check("sim_ls_latency", 64'(lat_a), 64'd1);
    check("sim_if_latency", 64'(lat_b), 64'd3);

    // Starvation: LS x4, IF, LS x2
    for (int k = 0; k < 4; k++) push(1'b1, 1'b0, 64'h8000_2000 + 64'(8 * k), 64'(k), 3'd3);
    push(1'b0, 1'b0, 64'h8000_0000, 64'd0, 3'd2);
    for (int k = 4; k < 6; k++) push(1'b1, 1'b0, 64'h8000_2000 + 64'(8 * k), 64'(k), 3'd3);
    fork
      ls_seq(6, 1'b0, 64'h8000_2000, 64'd0, 3'd3, lat_a);
      drive_if(64'h8000_0000, 3'd2, lat_b);
    join
    check("starve_if_latency", 64'(lat_b), 64'd9);

    // Asynchronous reset while the LSU owns the port
    mem_lat = 20;
    @(posedge clk);
    #1;
    i_ls_valid = 1'b1;
    i_ls_wen   = 1'b1;
    i_ls_addr  = 64'h8000_4000;
    i_ls_wdata = 64'h1234_5678;
    i_ls_size  = 3'd3;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_busy) break;
    end
    check("busy_before_reset", 64'(o_busy), 64'd1);
    #2;
    rst_n = 1'b0;
    i_ls_valid = 1'b0;
    #1;
    check("async_rst_mem_valid", 64'(o_mem_valid), 64'd0);
    check("async_rst_busy", 64'(o_busy), 64'd0);
    check("async_rst_mem_addr", o_mem_addr, 64'd0);
    check("async_rst_mem_wen", 64'(o_mem_wen), 64'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    mem_lat = 0;
    push(1'b0, 1'b0, 64'h8000_0000, 64'd0, 3'd2);
    drive_if(64'h8000_0000, 3'd2, lat_a);
    check("post_reset_if_latency", 64'(lat_a), 64'd1);

    // Stray ready while idle
    @(negedge clk);
    stray_req = 1'b1;
    @(posedge clk);
    #2;
    stray_req = 1'b0;
    @(posedge clk);
    #2;
    check("stray_busy", 64'(o_busy), 64'd0);
    check("stray_mem_valid", 64'(o_mem_valid), 64'd0);

    repeat (3) @(posedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
